// File: rtl/bus_arbiter4_pkg.sv
// Shared types and constants for the four-master write-bus arbiter.
package bus_arb_pkg;

  localparam int NUM_MASTERS = 4;

  // Owner index: selects one of the four masters through the data mux.
  typedef logic [1:0] owner_t;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } state_t;

  // Same encodings as plain constants for logic-typed state registers.
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GRANT = 2'b01;
  localparam logic [1:0] S_TURN  = 2'b10;

  // One-hot grant vector for a given owner index.
  function automatic logic [NUM_MASTERS-1:0] owner_onehot(input owner_t owner);
    owner_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner;
  endfunction

endpackage

// File: rtl/bus_arbiter4_if.sv
// Request/grant/select bundle between the four write masters, the SDRAM
// accept signal and the arbiter. The master view drives the requests, beat
// valids and the SDRAM accept; the slave view is the arbiter itself.
interface bus_arbiter4_if;
  import bus_arb_pkg::*;

  logic [NUM_MASTERS-1:0] Req;
  logic [NUM_MASTERS-1:0] Valid;
  logic                   Ready;
  logic [NUM_MASTERS-1:0] Gnt;
  owner_t                 Sel;
  logic                   BusValid;
  logic                   Busy;

  modport master (
    output Req,
    output Valid,
    output Ready,
    input  Gnt,
    input  Sel,
    input  BusValid,
    input  Busy
  );

  modport slave (
    input  Req,
    input  Valid,
    input  Ready,
    output Gnt,
    output Sel,
    output BusValid,
    output Busy
  );

endinterface

// File: rtl/rr_priority4.sv
// Combinational round-robin picker: the search starts at the master just
// after LastOwner and wraps, so LastOwner itself is checked last and only
// wins when it is the sole requester.
module rr_priority4
  import bus_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] Req,
  input  owner_t                 LastOwner,
  output owner_t                 Winner,
  output logic                   AnyReq
);

  // Requests rotated so that bit 0 is the master right after LastOwner.
  logic [NUM_MASTERS-1:0] rot_req;
  owner_t                 offset;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
    assign rot_req[gi] = Req[owner_t'(LastOwner + owner_t'(gi + 1))];
  end

  // Lowest set bit of the rotated vector is the nearest requester.
  always_comb begin
    offset = owner_t'(NUM_MASTERS - 1);
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        offset = owner_t'(i);
      end
    end
  end

  // With no request the result is LastOwner; callers gate on AnyReq.
  assign Winner = owner_t'(LastOwner + offset + 2'd1);
  assign AnyReq = |Req;

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin owner of the SDRAM write bus. Grants one master at a time for
// up to BURST_LEN accepted beats, drives the mux select, qualifies the muxed
// beat with BusValid and inserts one idle TURN cycle between owners.
module bus_arbiter4
  import bus_arb_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  bus_arbiter4_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  logic [1:0]             state_reg, state_next;
  logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
  owner_t                 sel_reg, sel_next;
  owner_t                 last_owner_reg, last_owner_next;
  logic [CNT_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next;
  logic                   busy_reg;

  owner_t                 pick_base;
  owner_t                 winner;
  logic                   any_req;
  logic                   beat;
  logic                   last_beat;
  logic                   owner_req;

  // In TURN the owner being released is still in sel_reg; using it directly
  // lets arbitration see the updated LastOwner in the same cycle.
  assign pick_base = (state_reg == S_TURN) ? sel_reg : last_owner_reg;

  rr_priority4 u_pick (
    .Req       (bus.Req),
    .LastOwner (pick_base),
    .Winner    (winner),
    .AnyReq    (any_req)
  );

  assign owner_req = bus.Req[sel_reg];
  assign beat      = (state_reg == S_GRANT) && bus.Valid[sel_reg] && bus.Ready;
  assign last_beat = beat && (beat_cnt_reg == LAST_BEAT);

  // Next-state, grant, select and beat-count decisions.
  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    sel_next        = sel_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;

    case (state_reg)
      S_IDLE: begin
        gnt_next = '0;
        if (any_req) begin
          state_next    = S_GRANT;
          gnt_next      = owner_onehot(winner);
          sel_next      = winner;
          beat_cnt_next = '0;
        end
      end

      S_GRANT: begin
        // A beat in the same cycle as a request drop still counts.
        if (beat) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
        if (last_beat || !owner_req) begin
          state_next = S_TURN;
          gnt_next   = '0;
        end
      end

      S_TURN: begin
        last_owner_next = sel_reg;
        gnt_next        = '0;
        if (any_req) begin
          state_next    = S_GRANT;
          gnt_next      = owner_onehot(winner);
          sel_next      = winner;
          beat_cnt_next = '0;
        end else begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State registers; reset leaves master 0 first in line (LastOwner = 3).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= S_IDLE;
      gnt_reg        <= '0;
      sel_reg        <= '0;
      last_owner_reg <= owner_t'(NUM_MASTERS - 1);
      beat_cnt_reg   <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      sel_reg        <= sel_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      busy_reg       <= (state_next != S_IDLE);
    end
  end

  // Beat strobe is combinational from Valid; gated by the registered grant.
  assign bus.BusValid = bus.Valid[sel_reg] && (gnt_reg != '0);
  assign bus.Gnt      = gnt_reg;
  assign bus.Sel      = sel_reg;
  assign bus.Busy     = busy_reg;

endmodule
